// File: rtl/vbuf_pkg.sv
// Shared constants and helpers for the vbuf_pipe elastic buffer.
package vbuf_pkg;

  localparam int unsigned DEPTH_MAX   = 16;
  localparam int unsigned STALL_CNT_W = 16;

  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/vbuf_stage.sv
// One elastic stage: a valid flag and a data register, loaded whenever the stage is ready.
module vbuf_stage #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             down_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic ready;
  assign ready = ~valid | down_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     valid <= 1'b0;
    else if (flush) valid <= 1'b0;
    else if (ready) valid <= up_valid;
  end

  always_ff @(posedge clk) begin
    if (ready && up_valid) data <= up_data;
  end

endmodule

// File: rtl/vbuf_pipe.sv
// Multi-lane elastic pipeline buffer with per-lane occupancy.
// Define VBUF_PIPE_STALL_CNT_EN to build the per-lane saturating stall counters.
module vbuf_pipe
  import vbuf_pkg::*;
#(
  parameter int WIDTH    = 1,
  parameter int DEPTH    = 3,
  parameter int CHANNELS = 2,
  localparam int OCC_W   = $clog2(DEPTH + 1)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  input  logic [CHANNELS-1:0]             in_valid,
  output logic [CHANNELS-1:0]             in_ready,
  input  logic [CHANNELS*WIDTH-1:0]       in_data,
  output logic [CHANNELS-1:0]             out_valid,
  input  logic [CHANNELS-1:0]             out_ready,
  output logic [CHANNELS*WIDTH-1:0]       out_data,
  output logic [CHANNELS*OCC_W-1:0]       occupancy,
  output logic [CHANNELS*STALL_CNT_W-1:0] stall_cnt
);

  if (DEPTH < 1 || DEPTH > int'(DEPTH_MAX) || CHANNELS < 1) begin : g_param_check
    $error("vbuf_pipe: DEPTH must be 1..16 and CHANNELS >= 1");
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    // vv[i]/dd[i] feed stage i; vv[i+1]/dd[i+1] are its registered outputs.
    logic [DEPTH:0]   vv;
    logic [WIDTH-1:0] dd [DEPTH+1];
    logic [DEPTH:0]   rdy;
    logic             in_x, out_x;
    logic [OCC_W-1:0] occ_q;

    assign vv[0] = in_valid[k] & ~flush;
    assign dd[0] = in_data[k*WIDTH +: WIDTH];

    // Ready of stage i expanded flat: some stage at or after i is empty, or the sink takes.
    always_comb begin
      rdy = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        rdy[i] = out_ready[k];
        for (int unsigned j = i; j < DEPTH; j++) rdy[i] = rdy[i] | ~vv[j+1];
      end
      rdy[DEPTH] = out_ready[k];
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      vbuf_stage #(.WIDTH(WIDTH)) u_stage (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .up_valid   (vv[i]),
        .up_data    (dd[i]),
        .down_ready (rdy[i+1]),
        .valid      (vv[i+1]),
        .data       (dd[i+1])
      );
    end

    assign in_ready[k]                  = rdy[0] & ~flush;
    assign out_valid[k]                 = vv[DEPTH];
    assign out_data[k*WIDTH +: WIDTH]   = dd[DEPTH];
    assign in_x                         = in_valid[k] & in_ready[k];
    assign out_x                        = vv[DEPTH] & out_ready[k];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     occ_q <= '0;
      else if (flush) occ_q <= '0;
      else            occ_q <= occ_q + OCC_W'(in_x) - OCC_W'(out_x);
    end
    assign occupancy[k*OCC_W +: OCC_W] = occ_q;

`ifdef VBUF_PIPE_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                       stall_q <= '0;
      else if (flush)                   stall_q <= '0;
      else if (vv[DEPTH] & ~out_ready[k]) stall_q <= sat_inc(stall_q);
    end
    assign stall_cnt[k*STALL_CNT_W +: STALL_CNT_W] = stall_q;
`else
    assign stall_cnt[k*STALL_CNT_W +: STALL_CNT_W] = '0;
`endif
  end

endmodule

// File: tb/tb_vbuf_pipe.sv
// Scoreboard bench for vbuf_pipe: random per-lane traffic against a FIFO-of-words reference.
module tb_vbuf_pipe;

  localparam int W  = 8;
  localparam int D  = 3;
  localparam int CH = 2;
  localparam int OW = $clog2(D + 1);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic [CH-1:0]   in_valid = '0;
  logic [CH-1:0]   in_ready;
  logic [CH*W-1:0] in_data = '0;
  logic [CH-1:0]   out_valid;
  logic [CH-1:0]   out_ready = '0;
  logic [CH*W-1:0] out_data;
  logic [CH*OW-1:0] occupancy;
  logic [CH*16-1:0] stall_cnt;

  vbuf_pipe #(.WIDTH(W), .DEPTH(D), .CHANNELS(CH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    int           t;
  } ent_t;

  ent_t        q [CH][$];
  logic [15:0] exp_st [CH];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic        er, eov;

  logic         src_v [CH];
  logic [W-1:0] src_d [CH];
  int           budget [CH];
  int           pin [CH];
  int           pout [CH];
  int           pflush = 0;

  task automatic chk(input string name, input int lane, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s lane%0d: got 0x%0h expected 0x%0h (cycle %0d)", name, lane, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: each lane is an ordered list of accepted words; the head shows at the
  // output once DEPTH edges have passed since it was accepted.
  always @(negedge clk) begin
    for (int k = 0; k < CH; k++) begin
      if (!rst_n) begin
        q[k].delete();
        exp_st[k] = '0;
        chk("rst_out_valid", k, 32'(out_valid[k]), 0);
        chk("rst_occupancy", k, 32'(occupancy[k*OW +: OW]), 0);
        chk("rst_stall_cnt", k, 32'(stall_cnt[k*16 +: 16]), 0);
      end else begin
        er  = !flush && (q[k].size() < D || out_ready[k]);
        eov = q[k].size() > 0 && cyc >= q[k][0].t + D - 1;
        chk("in_ready", k, 32'(in_ready[k]), 32'(er));
        chk("out_valid", k, 32'(out_valid[k]), 32'(eov));
        chk("occupancy", k, 32'(occupancy[k*OW +: OW]), q[k].size());
        chk("stall_cnt", k, 32'(stall_cnt[k*16 +: 16]), 32'(exp_st[k]));
        if (eov && out_ready[k]) begin
          chk("out_data", k, 32'(out_data[k*W +: W]), 32'(q[k][0].d));
          void'(q[k].pop_front());
        end
`ifdef VBUF_PIPE_STALL_CNT_EN
        if (flush) exp_st[k] = '0;
        else if (eov && !out_ready[k] && exp_st[k] != 16'hFFFF) exp_st[k] = exp_st[k] + 16'd1;
`endif
        if (flush) q[k].delete();
        else if (in_valid[k] && er) q[k].push_back('{d: in_data[k*W +: W], t: cyc + 1});
      end
    end
  end

  task automatic set_lane(input int k, input int b, input int pi, input int po);
    budget[k] = b;
    pin[k]    = pi;
    pout[k]   = po;
  endtask

  // Sources hold a word until it is taken, then optionally offer a fresh one.
  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      for (int k = 0; k < CH; k++) begin
        if (!src_v[k] && budget[k] > 0 && $urandom_range(99) < pin[k]) begin
          src_v[k] = 1'b1;
          src_d[k] = W'($urandom);
        end
        in_valid[k]         = src_v[k];
        in_data[k*W +: W]   = src_d[k];
        out_ready[k]        = ($urandom_range(99) < pout[k]);
      end
      flush = ($urandom_range(99) < pflush);
      #8;
      for (int k = 0; k < CH; k++) begin
        if (in_valid[k] && in_ready[k] && !flush && rst_n) begin
          src_v[k]  = 1'b0;
          budget[k] = budget[k] - 1;
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    for (int k = 0; k < CH; k++) begin
      src_v[k] = 1'b0;
      src_d[k] = '0;
      exp_st[k] = '0;
      set_lane(k, 0, 0, 100);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single word on lane 0, lane 1 idle.
    set_lane(0, 1, 100, 100);
    set_lane(1, 0, 0, 100);
    run(6);

    // Backpressure on lane 0: five words offered, only DEPTH taken.
    set_lane(0, 5, 100, 0);
    run(8);
    chk("bp_occupancy", 0, 32'(occupancy[0 +: OW]), D);
    chk("bp_in_ready", 0, 32'(in_ready[0]), 0);
    pout[0] = 100;
    run(10);

    // Continuous streaming on both lanes.
    set_lane(0, 20, 100, 100);
    set_lane(1, 20, 100, 100);
    run(26);

    // Flush a full lane while input is offered.
    set_lane(0, 3, 100, 0);
    set_lane(1, 0, 0, 100);
    run(5);
    chk("pre_flush_occupancy", 0, 32'(occupancy[0 +: OW]), D);
    budget[0] = 1;
    pflush = 100;
    run(1);
    pflush = 0;
    chk("post_flush_occupancy", 0, 32'(occupancy[0 +: OW]), 0);
    chk("post_flush_out_valid", 0, 32'(out_valid[0]), 0);

    // Random traffic with occasional flushes.
    set_lane(0, 400, 70, 60);
    set_lane(1, 400, 55, 75);
    pflush = 2;
    run(400);
    pflush = 0;

    // Asynchronous reset between edges while streaming.
    set_lane(0, 50, 90, 40);
    set_lane(1, 50, 90, 40);
    run(15);
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < CH; k++) begin
      chk("async_rst_out_valid", k, 32'(out_valid[k]), 0);
      chk("async_rst_occupancy", k, 32'(occupancy[k*OW +: OW]), 0);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run(30);

`ifdef VBUF_PIPE_STALL_CNT_EN
    set_lane(0, 0, 0, 100);
    set_lane(1, 1, 100, 0);
    run(70005);
    chk("stall_saturate", 1, 32'(stall_cnt[16 +: 16]), 32'h0000_FFFF);
`else
    set_lane(0, 0, 0, 100);
    set_lane(1, 1, 100, 0);
    run(40);
    chk("stall_tied_off", 1, 32'(stall_cnt[16 +: 16]), 0);
`endif

    for (int k = 0; k < CH; k++) set_lane(k, 0, 0, 100);
    run(10);
    for (int k = 0; k < CH; k++) chk("drained", k, q[k].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vbuf_pipe.md
VBUF_PIPE -- requirements
Module: vbuf_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 1: data bits per lane.
REQ-002 SHALL have parameter DEPTH, default 3: buffer stages per lane; legal range 1..16.
REQ-003 SHALL have parameter CHANNELS, default 2: independent lanes.
REQ-004 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port flush, input, 1: synchronous clear of all lanes.
REQ-007 SHALL have port in_valid, input, CHANNELS: per-lane upstream valid.
REQ-008 SHALL have port in_ready, output, CHANNELS: per-lane upstream ready.
REQ-009 SHALL have port in_data, input, CHANNELS*WIDTH: lane k in bits [k*WIDTH +: WIDTH].
REQ-010 SHALL have port out_valid, output, CHANNELS: per-lane downstream valid.
REQ-011 SHALL have port out_ready, input, CHANNELS: per-lane downstream ready.
REQ-012 SHALL have port out_data, output, CHANNELS*WIDTH: same packing as in_data.
REQ-013 SHALL have port occupancy, output, CHANNELS*OCC_W: per-lane count of full stages; OCC_W = $clog2(DEPTH+1).
REQ-014 SHALL have port stall_cnt, output, CHANNELS*16: per-lane stall counter (see Configuration).

Function
REQ-015 Each lane SHALL be DEPTH elastic stages in series, each holding one valid bit and WIDTH data bits; lanes share no state.
REQ-016 A transfer SHALL occur on a port when valid and ready are both high at the rising edge.
REQ-017 Stage i SHALL be ready when it is empty or stage i+1 (or out_ready for the last stage) accepts in the same cycle; in_ready is the ready of stage 0 (combinational ready chain).
REQ-018 out_valid and out_data SHALL be driven only from last-stage registers; no combinational path from in_* to out_*.
REQ-019 Latency for an unstalled lane SHALL be exactly DEPTH cycles from input transfer to out_valid.
REQ-020 Throughput SHALL be one transfer per lane per cycle when out_ready is held high.
REQ-021 Data SHALL leave each lane in acceptance order, with no loss and no duplication.
REQ-022 With out_ready low, a lane SHALL accept exactly DEPTH words, then drop in_ready; out_data SHALL stay stable while out_valid is high and out_ready is low.
REQ-023 occupancy SHALL equal the number of valid stages, registered, updated every cycle; a simultaneous input and output transfer leaves it unchanged.
REQ-024 When flush is high, all valid bits SHALL clear at the next edge, occupancy SHALL become 0, and in_ready SHALL be forced low that cycle, so that no input transfer occurs.
REQ-025 Data registers need not reset; valid bits SHALL.

Reset
REQ-026 While rst_n is low, all valid bits, occupancy and stall_cnt SHALL be 0 immediately (asynchronous), and out_valid SHALL be 0.
REQ-027 Reset deassertion SHALL be synchronised externally; the block SHALL accept input the first edge after rst_n rises.
REQ-028 Reset during an in-flight transfer SHALL discard all buffered words.

Configuration
REQ-029 Macro VBUF_PIPE_STALL_CNT_EN SHALL, when defined, enable per-lane 16-bit counters that increment each cycle out_valid=1 and out_ready=0, saturate at 0xFFFF, and clear on reset or flush.
REQ-030 Without VBUF_PIPE_STALL_CNT_EN, stall_cnt SHALL be tied to 0 and no counter logic SHALL be synthesised; the port list SHALL be unchanged.

Structure
REQ-031 Package vbuf_pkg SHALL hold the DEPTH_MAX=16 constant, the STALL_CNT_W=16 constant and the saturating-increment function.
REQ-032 Sub-module vbuf_stage (one elastic stage: valid/ready/data register) SHALL be instantiated DEPTH times per lane via generate.
REQ-033 An elaboration-time check SHALL reject DEPTH outside 1..16 and CHANNELS<1.

Verification
REQ-034 DEPTH=3, CHANNELS=2, out_ready=1: drive lane0 with 0x1 at cycle 0 -> out_valid[0]=1 with data 0x1 at cycle 3; lane1 stays idle.
REQ-035 out_ready[0]=0, stream 5 words into lane0 -> 3 accepted, in_ready[0]=0, occupancy lane0=3; release out_ready -> words 1,2,3 emerge in order, then 4,5.
REQ-036 Continuous streaming with out_ready=1 for 20 cycles -> 20 words out, back-to-back, occupancy constant at 3.
REQ-037 Lane0 full, assert flush for 1 cycle with in_valid=1 -> occupancy=0 next cycle, no input accepted during flush, out_valid=0.
REQ-038 Assert rst_n=0 mid-stream, asynchronously between edges -> out_valid and occupancy go to 0 before the next edge.
REQ-039 With VBUF_PIPE_STALL_CNT_EN defined, stall lane1 for 70000 cycles -> stall_cnt lane1=0xFFFF; without the macro, stall_cnt=0.
